// File: rtl/cmp_sched_pkg.sv
// rtl/cmp_sched_pkg.sv - shared types and round-robin search for the comparator scheduler
package cmp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam int MAX_REQ  = 8;

    // Returns {found, index}; scans from last+1 upward with wrap, first hit wins.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 num_req,
        input int                 last
    );
        logic [3:0] pick;
        int         idx;
        pick = 4'd0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= num_req) begin
                idx = (last + i) % num_req;
                if (valid[idx[2:0]]) begin
                    pick = {1'b1, idx[2:0]};
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/FourBitComparator.sv
// rtl/FourBitComparator.sv - 4-bit equality cell
module FourBitComparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       aeqb
);

    assign aeqb = &(a ~^ b);

endmodule

// File: rtl/shared_comparator_scheduler.sv
// rtl/shared_comparator_scheduler.sv - round-robin sharing of one 4-bit comparator across requesters
module shared_comparator_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_eq,
    output logic                       busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic [ID_W-1:0]    cur_id;
    logic [2:0]         last_grant;
    logic [CNT_W-1:0]   cnt;
    logic               eq_acc;

    logic [3:0]         pick;
    logic               found;
    logic [2:0]         win;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic               aeqb;
    logic               last_nib;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req_valid), NUM_REQ, int'(last_grant));
        found = pick[3];
        win   = pick[2:0];
    end

    // Gated by rst_n so nothing looks accepted while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) begin
            req_ready = NUM_REQ'(1) << win;
        end
    end

    assign nib_a    = cap_a[{cnt, 2'b00} +: NIBBLE_W];
    assign nib_b    = cap_b[{cnt, 2'b00} +: NIBBLE_W];
    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));
    assign busy     = (state != IDLE);

    FourBitComparator uut (
        .a    (nib_a),
        .b    (nib_b),
        .aeqb (aeqb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_a      <= '0;
            cap_b      <= '0;
            cur_id     <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            cnt        <= '0;
            eq_acc     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_eq     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cap_a      <= req_a[win*WIDTH +: WIDTH];
                        cap_b      <= req_b[win*WIDTH +: WIDTH];
                        cur_id     <= ID_W'(win);
                        last_grant <= win;
                        cnt        <= '0;
                        eq_acc     <= 1'b1;
                        state      <= COMPARE;
                    end
                end
                COMPARE: begin
                    // The response is registered on the way into DONE so it is visible during DONE.
                    if (!aeqb || last_nib) begin
                        eq_acc    <= eq_acc & aeqb;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_eq    <= eq_acc & aeqb;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
